// File: rtl/iob_master_ctrl.sv
// IOB-side bus master engine: takes one request from the FSB-side slave
// (IOREQ/IOACT handshake) and runs a complete 68000-style asynchronous bus
// cycle, including VPA/VMA cycles against a generated E clock, bus error
// termination and a wait-state watchdog. All outputs are registered so the
// strobes reach the I/O bus glitch-free.
module iob_master_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic CLK,
  input  logic RST,
  input  logic IOREQ,
  input  logic IORW0,
  input  logic IOL0,
  input  logic IOU0,
  output logic IOACT,
  input  logic nDTACK,
  input  logic nVPA,
  input  logic nBERR,
  output logic E,
  output logic nVMA,
  output logic nAS,
  output logic nUDS,
  output logic nLDS,
  output logic IORW,
  output logic nDoutOE,
  output logic nDinLE,
  output logic IOERR
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_S0, ST_S1, ST_S2, ST_S3, ST_S4, ST_S5, ST_S6, ST_S7, ST_VMA
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t     state, state_n;
  logic       ioreq_s1, ioreq_r, dtack_r, vpa_r, berr_r;
  logic [3:0] ecnt, ecnt_n;
  logic [7:0] wait_cnt, wait_n;
  logic       arm, arm_n, rw, rw_n, lo, lo_n, up, up_n, err, err_n;
  logic       bus_on, strobe_on;
  logic       ioact_n, nas_n, nuds_n, nlds_n, iorw_n;
  logic       ndoutoe_n, ndinle_n, nvma_n, ioerr_n, e_n;

  // Synchronise the request and register the peripheral acknowledges once.
  always_ff @(posedge CLK) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values, exactly like the hardware it describes.
    if (RST) begin
      ioreq_s1 <= 1'b0;
      ioreq_r  <= 1'b0;
      dtack_r  <= 1'b1;
      vpa_r    <= 1'b1;
      berr_r   <= 1'b1;
    end else begin
      ioreq_s1 <= IOREQ;
      ioreq_r  <= ioreq_s1;
      dtack_r  <= nDTACK;
      vpa_r    <= nVPA;
      berr_r   <= nBERR;
    end
  end

  // Next state, latched request fields and the next value of every output.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_n = state;
    arm_n   = arm;
    rw_n    = rw;
    lo_n    = lo;
    up_n    = up;
    err_n   = err;
    wait_n  = wait_cnt;
    ecnt_n  = (ecnt == 4'd9) ? 4'd0 : ecnt + 4'd1;

    // Re-arm only once the request has been seen low, so one request
    // can never launch two cycles.
    if (!ioreq_r) arm_n = 1'b1;

    case (state)
      ST_IDLE: begin
        if (ioreq_r && arm) begin
          state_n = ST_S0;
          rw_n    = IORW0;
          lo_n    = IOL0;
          up_n    = IOU0;
        end
      end
      ST_S0: state_n = ST_S1;
      ST_S1: state_n = ST_S2;
      ST_S2: state_n = ST_S3;
      ST_S3: state_n = ST_S4;
      ST_S4: begin
        if (!berr_r) begin
          err_n   = 1'b1;
          state_n = ST_S5;
        end else if (!dtack_r) begin
          state_n = ST_S5;
        end else if (!vpa_r) begin
          state_n = ST_VMA;
        end else if (wait_cnt == TIMEOUT_CNT) begin
          err_n   = 1'b1;
          state_n = ST_S5;
        end else begin
          wait_n = (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;
        end
      end
      ST_VMA: begin
        // Leaving at Ecnt = 7 puts S5 on 8, S6 on 9 and S7 on the E fall.
        if (!berr_r) begin
          err_n   = 1'b1;
          state_n = ST_S5;
        end else if (!nVMA && ecnt == 4'd7) begin
          state_n = ST_S5;
        end
      end
      ST_S5:   state_n = ST_S6;
      ST_S6:   state_n = ST_S7;
      ST_S7:   state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase

    if (state_n == ST_S0) begin
      arm_n  = 1'b0;
      wait_n = 8'd0;
    end
    if (state_n == ST_IDLE) err_n = 1'b0;

    // Outputs follow the state being entered, so they change on that edge.
    bus_on    = state_n inside {ST_S2, ST_S3, ST_S4, ST_S5, ST_S6, ST_VMA};
    strobe_on = rw_n ? bus_on : (state_n inside {ST_S4, ST_S5, ST_S6, ST_VMA});
    ioact_n   = (state_n != ST_IDLE);
    nas_n     = ~bus_on;
    nuds_n    = ~(strobe_on & up_n);
    nlds_n    = ~(strobe_on & lo_n);
    iorw_n    = (state_n == ST_IDLE) ? 1'b1 : rw_n;
    ndoutoe_n = ~(~rw_n & (state_n inside {ST_S3, ST_S4, ST_S5, ST_S6, ST_S7, ST_VMA}));
    ndinle_n  = ~((state_n == ST_S6) & rw_n & ~err_n);
    ioerr_n   = (state_n == ST_S7) & err_n;
    e_n       = (ecnt_n >= 4'd6);

    // VMA asserts at Ecnt = 3 and holds through S6.
    if (state_n == ST_VMA && ecnt_n == 4'd3)
      nvma_n = 1'b0;
    else if (state_n inside {ST_VMA, ST_S5, ST_S6})
      nvma_n = nVMA;
    else
      nvma_n = 1'b1;
  end

  // State, request fields, counters and output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= ST_IDLE;
      arm      <= 1'b1;
      rw       <= 1'b1;
      lo       <= 1'b0;
      up       <= 1'b0;
      err      <= 1'b0;
      wait_cnt <= 8'd0;
      ecnt     <= 4'd0;
      IOACT    <= 1'b0;
      nAS      <= 1'b1;
      nUDS     <= 1'b1;
      nLDS     <= 1'b1;
      IORW     <= 1'b1;
      nVMA     <= 1'b1;
      nDoutOE  <= 1'b1;
      nDinLE   <= 1'b1;
      IOERR    <= 1'b0;
      E        <= 1'b0;
    end else begin
      state    <= state_n;
      arm      <= arm_n;
      rw       <= rw_n;
      lo       <= lo_n;
      up       <= up_n;
      err      <= err_n;
      wait_cnt <= wait_n;
      ecnt     <= ecnt_n;
      IOACT    <= ioact_n;
      nAS      <= nas_n;
      nUDS     <= nuds_n;
      nLDS     <= nlds_n;
      IORW     <= iorw_n;
      nVMA     <= nvma_n;
      nDoutOE  <= ndoutoe_n;
      nDinLE   <= ndinle_n;
      IOERR    <= ioerr_n;
      E        <= e_n;
    end
  end

endmodule

// File: doc/iob_master_ctrl.md
# iob_master_ctrl

IOB-side bus master engine answering the IOREQ/IOACT handshake from the FSB-side I/O slave. It takes one queued request (direction and byte lanes) and runs a complete MC68000-style asynchronous bus cycle on the I/O bus: AS/UDS/LDS sequencing, DTACK/BERR termination, VPA/VMA synchronous cycles against a generated E clock, and a watchdog. It drives the data-path latch and output-enable strobes, and holds IOACT for the whole cycle so the slave can queue the next request.

## Interface
- TIMEOUT, 255: wait-state cycles allowed in S4 before forced termination.

- CLK  in  1  IOB state clock; one 68000 half-clock state (Sn) per CLK cycle.
- RST  in  1  synchronous reset, active-high.
- IOREQ  in  1  request from the FSB-side slave; asynchronous to CLK.
- IORW0  in  1  request direction, 1 = read; stable while IOREQ is high.
- IOL0  in  1  lower byte lane requested.
- IOU0  in  1  upper byte lane requested.
- IOACT  out  1  cycle in progress.
- nDTACK, nVPA, nBERR  in  1 each  peripheral acknowledges, active-low, asynchronous.
- E  out  1  6800-style E clock, period of 10 CLK cycles.
- nVMA  out  1  valid memory address for VPA cycles.
- nAS, nUDS, nLDS  out  1 each  I/O bus strobes.
- IORW  out  1  I/O bus R/W.
- nDoutOE  out  1  write-data output enable.
- nDinLE  out  1  read-data latch enable; data is captured on its rising edge.
- IOERR  out  1  one-cycle pulse on bus error or timeout.

## Operation
- IOREQ passes through a 2-flop synchronizer (IOREQr). nDTACK, nVPA and nBERR are each registered once (DTACKr, VPAr, BERRr).
- Arm flag:
  - Set by reset and whenever IOREQr = 0.
  - Cleared on entry to S0.
  - A cycle starts only when IOREQr = 1 and the arm flag is set, so a single request never runs twice.
- E counter Ecnt runs 0..9 continuously. E = 1 when Ecnt ≥ 6.
- States are IDLE, S0–S7 and VMA.
- IDLE:
  - IOACT = 0.
  - On start, go to S0. Latch RW = IORW0, L = IOL0, U = IOU0.
- S0: IOACT = 1, IORW = RW.
- S1: no output change.
- S2:
  - nAS = 0.
  - On a read, nUDS = ~U and nLDS = ~L.
- S3: on a write, nDoutOE = 0. It stays low until IDLE.
- S4:
  - On a write, nUDS = ~U and nLDS = ~L.
  - Each cycle, evaluate in priority order:
    1. BERRr = 0: set err, go to S5.
    2. DTACKr = 0: go to S5.
    3. VPAr = 0: go to VMA.
    4. Wait counter = TIMEOUT: set err, go to S5.
    5. Otherwise stay in S4 and increment the wait counter.
  - The wait counter is 8 bits, clears on S0 and saturates.
- VMA:
  - nVMA = 0 on the cycle Ecnt = 3.
  - Once nVMA is low, go to S5 when Ecnt = 8, so that S6 falls on Ecnt = 9 and S7 on Ecnt = 0 (the E falling edge).
  - BERRr = 0 here is handled as in S4.
- S5: no output change.
- S6: on a read with err clear, nDinLE = 0 for exactly this cycle.
- S7:
  - nAS, nUDS, nLDS and nVMA return to 1.
  - IOERR = err for this one cycle.
  - Next state is IDLE. On IDLE entry, IOACT = 0, IORW = 1, nDoutOE = 1 and err clears.
- Reset values: IOACT 0, nAS/nUDS/nLDS 1, IORW 1, nVMA 1, nDoutOE 1, nDinLE 1, IOERR 0, E 0, Ecnt 0, state IDLE, arm 1.
- RST mid-cycle forces the reset values on the next edge. No S7 is run and no IOERR is pulsed.

## Timing
- Start latency: IOREQ rising edge sampled at edge 1, IOREQr high after edge 2, S0 (IOACT = 1) after edge 3.
- A zero-wait cycle occupies S0–S7, so IOACT is high for exactly 8 CLK cycles.
- Each S4 wait adds one cycle.
- The minimum DTACK-terminated cycle requires nDTACK low by the edge entering S4; DTACKr is then low in S4 and S4 lasts one cycle.
- A VPA cycle lasts between 10 and 20+ cycles. S6 always coincides with E high (Ecnt = 9).
- IOACT falls on IDLE entry, never before S7 completes.
- The FSB side may drop IOREQ at any time after IOACT rises. This has no effect on the cycle in progress.

## Test plan
- Read with IOL0 = IOU0 = 1 and nDTACK tied low: IOREQ rises → IOACT high after edge 3 for 8 cycles; nAS, nUDS and nLDS low from S2 through S6; nDinLE low only in S6; IOERR stays 0.
- Lower-byte write with nDTACK falling 5 cycles after S4 entry: nDoutOE low from S3 through S7; nLDS low from S4; nUDS stays 1; S4 lasts 6 cycles; IOACT high for 13 cycles.
- Read with nVPA low in S4 at Ecnt = 5: nVMA low at the next Ecnt = 3; S6 at Ecnt = 9; nDinLE low in S6; nVMA high at S7.
- Write with nBERR and nDTACK both low in S4: BERR wins; IOERR pulses exactly once in S7; nDinLE never low.
- No acknowledge with TIMEOUT = 4: S4 lasts 5 cycles, then S5–S7 run and IOERR pulses once. Then hold IOREQ high: no second cycle starts until IOREQ has been low for at least one synchronized cycle.
- Assert RST in the 3rd S4 wait cycle: next edge gives IDLE with all outputs at their reset values. With IOREQ still high, a new cycle starts 3 edges after RST is released.
